// File: rtl/hex_key_pkg.sv
// hex_key_pkg: debounce state encoding and keypad-index-to-ASCII map.
package hex_key_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} key_state_e;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    function automatic logic [7:0] key_ascii(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h31;
            4'd1:    return 8'h32;
            4'd2:    return 8'h33;
            4'd3:    return 8'h41;
            4'd4:    return 8'h34;
            4'd5:    return 8'h35;
            4'd6:    return 8'h36;
            4'd7:    return 8'h42;
            4'd8:    return 8'h37;
            4'd9:    return 8'h38;
            4'd10:   return 8'h39;
            4'd11:   return 8'h43;
            4'd12:   return 8'h45;
            4'd13:   return 8'h30;
            4'd14:   return 8'h46;
            default: return 8'h44;
        endcase
    endfunction
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: drives rows one slot at a time, samples synchronized columns
// at slot end and reports the lowest pressed key index once per full scan.
module keypad_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       iCLK,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       scan_done,
    output logic       key_present,
    output logic [3:0] key_idx
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    logic [3:0] s1_q, s2_q, row_n_q, row_n_d, acc_q, acc_d, idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0] row_q, row_d, col;
    logic hit_q, hit_d, done_q, done_d, pres_q, pres_d, last, row_hit;
    always_comb begin
        last    = div_q == DW'(SCAN_DIV - 1);
        row_hit = s2_q != 4'hF;
        col     = !s2_q[0] ? 2'd0 : !s2_q[1] ? 2'd1 : !s2_q[2] ? 2'd2 : 2'd3;
        div_d   = last ? '0 : div_q + 1'b1;
        row_d   = last ? row_q + 2'd1 : row_q;
        row_n_d = last ? {row_n_q[2:0], row_n_q[3]} : row_n_q;
        hit_d   = hit_q;
        acc_d   = acc_q;
        // Rows are visited in ascending order, so the first hit is the lowest index.
        if (last && !hit_q && row_hit) begin
            hit_d = 1'b1;
            acc_d = {row_q, col};
        end
        done_d = last && row_q == 2'd3;
        pres_d = pres_q;
        idx_d  = idx_q;
        if (done_d) begin
            pres_d = hit_d;
            idx_d  = acc_d;
            hit_d  = 1'b0;
            acc_d  = '0;
        end
    end
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 4'hF;
            s2_q    <= 4'hF;
            div_q   <= '0;
            row_q   <= '0;
            row_n_q <= 4'b1110;
            hit_q   <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            pres_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            s1_q    <= col_n;
            s2_q    <= s1_q;
            div_q   <= div_d;
            row_q   <= row_d;
            row_n_q <= row_n_d;
            hit_q   <= hit_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            pres_q  <= pres_d;
            idx_q   <= idx_d;
        end
    end
    assign row_n       = row_n_q;
    assign scan_done   = done_q;
    assign key_present = pres_q;
    assign key_idx     = idx_q;
endmodule

// File: rtl/hex_key_entry.sv
// hex_key_entry: debounces scanned keypad results into letter/count updates;
// each accepted press and each accepted release advance count once.
module hex_key_entry
    import hex_key_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4,
    parameter int COUNT_MAX = 56
) (
    input  logic        iCLK,
    input  logic        rst_n,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [8:0]  letter,
    output logic [30:0] count,
    output logic        key_valid
);
    localparam int BW = $clog2(DEB_SCANS + 1);
    logic scan_done, key_present, valid_q, valid_d, deb_end;
    logic [3:0] key_idx, cand_q, cand_d;
    logic [BW-1:0] deb_q, deb_d, deb_nx;
    logic [8:0] letter_q, letter_d;
    logic [30:0] count_q, count_d, count_inc;
    key_state_e state_q, state_d;
    keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .iCLK       (iCLK),
        .rst_n      (rst_n),
        .col_n      (col_n),
        .row_n      (row_n),
        .scan_done  (scan_done),
        .key_present(key_present),
        .key_idx    (key_idx)
    );
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        deb_d     = deb_q;
        letter_d  = letter_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        deb_nx    = deb_q + 1'b1;
        deb_end   = deb_nx >= BW'(DEB_SCANS);
        count_inc = count_q < 31'(COUNT_MAX) ? count_q + 31'd1 : count_q;
        if (scan_done) begin
            case (state_q)
                IDLE: if (key_present) begin
                    state_d = PRESS_DEB;
                    cand_d  = key_idx;
                    deb_d   = BW'(1);
                end
                PRESS_DEB: if (!key_present) state_d = IDLE;
                else if (key_idx != cand_q) begin
                    cand_d = key_idx;
                    deb_d  = BW'(1);
                end else if (deb_end) begin
                    state_d  = HELD;
                    deb_d    = deb_nx;
                    letter_d = {1'b0, key_ascii(cand_q)};
                    count_d  = count_inc;
                    valid_d  = 1'b1;
                end else deb_d = deb_nx;
                HELD: if (!key_present) begin
                    state_d = REL_DEB;
                    deb_d   = BW'(1);
                end
                default: if (key_present) state_d = HELD;
                else if (deb_end) begin
                    state_d = IDLE;
                    deb_d   = deb_nx;
                    count_d = count_inc;
                end else deb_d = deb_nx;
            endcase
        end
    end
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            deb_q    <= '0;
            letter_q <= {1'b0, ASCII_SPACE};
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            deb_q    <= deb_d;
            letter_q <= letter_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end
    assign letter    = letter_q;
    assign count     = count_q;
    assign key_valid = valid_q;
endmodule

// File: tb/tb_hex_key_entry.sv
// tb_hex_key_entry: directed keypad scenarios with a behavioural key matrix.
module tb_hex_key_entry;
    logic        iCLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n, row_n;
    logic [8:0]  letter;
    logic [30:0] count;
    logic        key_valid;
    logic [15:0] keys = '0;
    int n_chk = 0, n_pass = 0, kv_cnt = 0, kv0 = 0;

    hex_key_entry #(.SCAN_DIV(4), .DEB_SCANS(2), .COUNT_MAX(56)) dut (
        .iCLK     (iCLK),
        .rst_n    (rst_n),
        .col_n    (col_n),
        .row_n    (row_n),
        .letter   (letter),
        .count    (count),
        .key_valid(key_valid)
    );

    always #5 iCLK = ~iCLK;

    always_comb begin
        col_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!row_n[2'(r)] && keys[4'(4 * r + c)]) col_n[2'(c)] = 1'b0;
    end

    always @(posedge iCLK) if (key_valid) kv_cnt <= kv_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic scans(input int n);
        repeat (n * 16) @(posedge iCLK);
        @(negedge iCLK);
    endtask

    initial begin
        int t, e;
        #23 rst_n = 1'b1;
        @(negedge iCLK);
        check("rst_row", 32'(row_n), 32'he);
        check("rst_letter", 32'(letter), 32'h20);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(key_valid), 0);

        for (int i = 0; i < 5; i++) begin
            keys[5] = (i % 2 == 0);
            scans(1);
        end
        keys = '0;
        scans(3);
        check("bounce_count", 32'(count), 0);
        check("bounce_kv", 32'(kv_cnt), 0);

        keys[6] = 1'b1;
        scans(1);
        check("six_early", 32'(count), 0);
        scans(2);
        check("six_count", 32'(count), 1);
        check("six_letter", 32'(letter), 32'h36);
        check("six_kv", 32'(kv_cnt), 1);
        keys = '0;
        scans(1);
        keys[6] = 1'b1;
        scans(2);
        check("relb_count", 32'(count), 1);
        check("relb_kv", 32'(kv_cnt), 1);
        keys = '0;
        scans(3);
        check("six_rel_count", 32'(count), 2);
        check("six_rel_kv", 32'(kv_cnt), 1);

        keys[3] = 1'b1;
        keys[13] = 1'b1;
        scans(3);
        check("multi_letter", 32'(letter), 32'h41);
        check("multi_count", 32'(count), 3);
        keys = '0;
        scans(3);
        check("multi_rel", 32'(count), 4);

        t = 0;
        while (row_n !== 4'b1011 && t < 100) begin
            @(negedge iCLK);
            t++;
        end
        check("row_wait", 32'(t < 100), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_row", 32'(row_n), 32'he);
        check("async_letter", 32'(letter), 32'h20);
        check("async_count", 32'(count), 0);
        check("async_valid", 32'(key_valid), 0);
        @(negedge iCLK);
        rst_n = 1'b1;

        keys[12] = 1'b1;
        scans(3);
        check("e_count", 32'(count), 1);
        check("e_letter", 32'(letter), 32'h45);
        #2 rst_n = 1'b0;
        #1;
        check("e_rst_count", 32'(count), 0);
        check("e_rst_letter", 32'(letter), 32'h20);
        repeat (3) @(negedge iCLK);
        kv0 = kv_cnt;
        rst_n = 1'b1;
        repeat (20) @(negedge iCLK);
        check("e_redeb_early", 32'(count), 0);
        scans(3);
        check("e_redeb_count", 32'(count), 1);
        check("e_redeb_letter", 32'(letter), 32'h45);
        check("e_redeb_kv", 32'(kv_cnt - kv0), 1);
        keys = '0;
        scans(3);
        check("e_rel", 32'(count), 2);

        rst_n = 1'b0;
        @(negedge iCLK);
        rst_n = 1'b1;
        kv0 = kv_cnt;
        for (int i = 1; i <= 30; i++) begin
            keys[14] = 1'b1;
            scans(3);
            e = (2 * i - 1 > 56) ? 56 : 2 * i - 1;
            check($sformatf("sat_press%0d", i), 32'(count), 32'(e));
            check($sformatf("sat_kv%0d", i), 32'(kv_cnt - kv0), 32'(i));
            if (i >= 29) check($sformatf("sat_letter%0d", i), 32'(letter), 32'h46);
            keys = '0;
            scans(3);
            e = (2 * i > 56) ? 56 : 2 * i;
            check($sformatf("sat_rel%0d", i), 32'(count), 32'(e));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
